// File: rtl/clk_freq_monitor.sv
// Frequency monitor: counts synchronized rising edges of sig_in over a fixed gate
// window of clkin, range-checks each count and derives a debounced lock flag.
module clk_freq_monitor #(
   parameter int GATE_CYCLES  = 100000,
   parameter int CNT_W        = 20,
   parameter int EXPECTED     = 25000,
   parameter int TOL          = 250,
   parameter int LOCK_WINDOWS = 4,
   parameter int SETTLE       = 4
) (
   input  logic             clkin,
   input  logic             reset,
   input  logic             enable,
   input  logic             sig_in,
   output logic [CNT_W-1:0] count_o,
   output logic             count_valid,
   output logic             in_range,
   output logic             locked,
   output logic             fail
);

   localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int LOCK_W = $clog2(LOCK_WINDOWS + 1);

   localparam logic [GATE_W-1:0] GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
   localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE - 1);
   localparam logic [LOCK_W-1:0] LOCK_MAX    = LOCK_W'(LOCK_WINDOWS);
   localparam logic signed [CNT_W:0] EXP_S   = (CNT_W + 1)'(EXPECTED);
   localparam logic signed [CNT_W:0] TOL_S   = (CNT_W + 1)'(TOL);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARM     = 2'd1;
   localparam logic [1:0] ST_MEASURE = 2'd2;

   logic [1:0]        state;
   logic              sync1, sync2, sync3;
   logic              edge_pulse;
   logic [GATE_W-1:0] gate_cnt;
   logic [SET_W-1:0]  settle_cnt;
   logic [CNT_W-1:0]  edge_cnt;
   logic [CNT_W-1:0]  result;
   logic [LOCK_W-1:0] lock_cnt;
   logic [LOCK_W-1:0] lock_next;
   logic signed [CNT_W:0] diff;
   logic              in_win;

   assign edge_pulse = sync2 & ~sync3;

   // Running count including this cycle's edge; saturates instead of wrapping.
   assign result = (edge_pulse && !(&edge_cnt)) ? edge_cnt + 1'b1 : edge_cnt;

   // Widened signed difference: no wrap, and a negative lower bound clamps to 0 naturally.
   assign diff   = $signed({1'b0, result}) - EXP_S;
   assign in_win = (diff >= -TOL_S) && (diff <= TOL_S);

   assign lock_next = (lock_cnt == LOCK_MAX) ? LOCK_MAX : lock_cnt + 1'b1;

   // NOTE: every register here, outputs included, is cleared by the synchronous reset so
   // downstream logic never sees a stale lock or count after reset.
   always_ff @(posedge clkin) begin
      if (reset) begin
         state       <= ST_IDLE;
         sync1       <= 1'b0;
         sync2       <= 1'b0;
         sync3       <= 1'b0;
         gate_cnt    <= '0;
         settle_cnt  <= '0;
         edge_cnt    <= '0;
         lock_cnt    <= '0;
         count_o     <= '0;
         count_valid <= 1'b0;
         in_range    <= 1'b0;
         locked      <= 1'b0;
         fail        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register samples the
         // pre-edge value of the others regardless of statement order.
         sync1       <= sig_in;
         sync2       <= sync1;
         sync3       <= sync2;
         count_valid <= 1'b0;
         fail        <= 1'b0;

         case (state)
            ST_IDLE: begin
               gate_cnt   <= '0;
               settle_cnt <= '0;
               edge_cnt   <= '0;
               lock_cnt   <= '0;
               locked     <= 1'b0;
               if (enable) state <= ST_ARM;
            end

            ST_ARM: begin
               if (!enable) begin
                  state <= ST_IDLE;
               end else if (settle_cnt == SETTLE_LAST) begin
                  state      <= ST_MEASURE;
                  settle_cnt <= '0;
                  gate_cnt   <= '0;
                  edge_cnt   <= '0;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end

            ST_MEASURE: begin
               if (!enable) begin
                  // Abort: partial count is discarded, last published result is kept.
                  state    <= ST_IDLE;
                  locked   <= 1'b0;
                  lock_cnt <= '0;
               end else if (gate_cnt == GATE_LAST) begin
                  gate_cnt    <= '0;
                  edge_cnt    <= '0;
                  count_o     <= result;
                  count_valid <= 1'b1;
                  in_range    <= in_win;
                  if (in_win) begin
                     lock_cnt <= lock_next;
                     if (lock_next == LOCK_MAX) locked <= 1'b1;
                  end else begin
                     lock_cnt <= '0;
                     locked   <= 1'b0;
                     fail     <= 1'b1;
                  end
               end else begin
                  gate_cnt <= gate_cnt + 1'b1;
                  edge_cnt <= result;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor with a short gate window; expected counts,
// latencies and lock behaviour are worked out by hand from the stimulus.
module tb_clk_freq_monitor;

   localparam int GATE = 100;
   localparam int SETL = 4;
   // Posedges from the first edge that samples enable=1 up to the one that raises count_valid.
   localparam int FIRST_LAT = 1 + SETL + GATE;

   logic       clkin = 1'b0;
   logic       reset;
   logic       enable;
   logic       sig_in;
   logic [7:0] count_o;
   logic       count_valid;
   logic       in_range;
   logic       locked;
   logic       fail;

   int n_tests = 0;
   int n_fail  = 0;

   // Stimulus generator controls: 0 = hold low, 1 = periodic, 2 = burst of pulses (period 3)
   int gen_mode   = 0;
   int per        = 4;
   int ph         = 0;
   int burst_left = 0;

   int fail_seen  = 0;
   int valid_seen = 0;
   int cyc;

   clk_freq_monitor #(
      .GATE_CYCLES (GATE),
      .CNT_W       (8),
      .EXPECTED    (25),
      .TOL         (1),
      .LOCK_WINDOWS(2),
      .SETTLE      (SETL)
   ) dut (
      .clkin      (clkin),
      .reset      (reset),
      .enable     (enable),
      .sig_in     (sig_in),
      .count_o    (count_o),
      .count_valid(count_valid),
      .in_range   (in_range),
      .locked     (locked),
      .fail       (fail)
   );

   initial forever #5 clkin = ~clkin;

   // sig_in changes on the falling edge, well away from the sampling edge.
   initial begin
      sig_in = 1'b0;
      forever begin
         @(negedge clkin);
         case (gen_mode)
            1: begin
               sig_in = (ph < 2);
               ph     = (ph + 1 >= per) ? 0 : ph + 1;
            end
            2: begin
               sig_in = (burst_left > 0) && (ph == 0);
               if (ph == 2 && burst_left > 0) burst_left--;
               ph = (ph == 2) ? 0 : ph + 1;
            end
            default: sig_in = 1'b0;
         endcase
      end
   end

   initial forever begin
      @(posedge clkin);
      #1;
      if (fail) fail_seen++;
      if (count_valid) valid_seen++;
   end

   task automatic check(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clkin);
         #1;
         n++;
      end while (!count_valid && n < 400);
      if (!count_valid) check("valid_timeout", 0, 1);
   endtask

   task automatic set_periodic(input int p);
      gen_mode = 1;
      per      = p;
      ph       = 0;
   endtask

   int burst_n[4]   = '{24, 26, 23, 27};
   int burst_rng[4] = '{1, 1, 0, 0};
   int burst_lck[4] = '{0, 1, 0, 0};

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      set_periodic(4);
      repeat (3) @(posedge clkin);
      #1;
      reset = 1'b0;
      @(posedge clkin);
      #1;
      check("rst_count_o", count_o, 0);
      check("rst_count_valid", count_valid, 0);
      check("rst_in_range", in_range, 0);
      check("rst_locked", locked, 0);
      check("rst_fail", fail, 0);

      // Period 4: 25 edges per window, lock after the second window.
      enable    = 1'b1;
      fail_seen = 0;
      wait_valid(cyc);
      check("p4_first_latency", cyc, FIRST_LAT);
      check("p4_w1_count", count_o, 25);
      check("p4_w1_in_range", in_range, 1);
      check("p4_w1_locked", locked, 0);
      wait_valid(cyc);
      check("p4_w2_period", cyc, GATE);
      check("p4_w2_count", count_o, 25);
      check("p4_w2_locked", locked, 1);
      wait_valid(cyc);
      check("p4_w3_period", cyc, GATE);
      check("p4_w3_locked", locked, 1);
      check("p4_no_fail", fail_seen, 0);

      // Period 5 while locked: the straddling window already fails and drops lock.
      set_periodic(5);
      wait_valid(cyc);
      check("p5_mixed_fail", fail, 1);
      check("p5_mixed_locked", locked, 0);
      wait_valid(cyc);
      check("p5_count", count_o, 20);
      check("p5_in_range", in_range, 0);
      check("p5_fail", fail, 1);
      check("p5_locked", locked, 0);

      // Back to period 4: relock after two full in-range windows.
      set_periodic(4);
      wait_valid(cyc);
      wait_valid(cyc);
      check("relock_w1_count", count_o, 25);
      wait_valid(cyc);
      check("relock_w2_locked", locked, 1);

      // sig_in stuck low.
      gen_mode = 0;
      wait_valid(cyc);
      for (int w = 0; w < 2; w++) begin
         wait_valid(cyc);
         check($sformatf("low_w%0d_count", w), count_o, 0);
         check($sformatf("low_w%0d_in_range", w), in_range, 0);
         check($sformatf("low_w%0d_fail", w), fail, 1);
         check($sformatf("low_w%0d_locked", w), locked, 0);
      end

      // Tolerance boundaries, one exact burst per window.
      for (int i = 0; i < 4; i++) begin
         gen_mode   = 2;
         ph         = 0;
         burst_left = burst_n[i];
         wait_valid(cyc);
         check($sformatf("tol%0d_count", burst_n[i]), count_o, burst_n[i]);
         check($sformatf("tol%0d_in_range", burst_n[i]), in_range, burst_rng[i]);
         check($sformatf("tol%0d_fail", burst_n[i]), fail, 1 - burst_rng[i]);
         check($sformatf("tol%0d_locked", burst_n[i]), locked, burst_lck[i]);
      end

      // Abort at gate cycle 50, then re-enable.
      set_periodic(4);
      wait_valid(cyc);
      wait_valid(cyc);
      wait_valid(cyc);
      check("pre_abort_locked", locked, 1);
      repeat (50) @(posedge clkin);
      #1;
      enable     = 1'b0;
      valid_seen = 0;
      @(posedge clkin);
      #1;
      check("abort_locked", locked, 0);
      check("abort_count_o_held", count_o, 25);
      check("abort_in_range_held", in_range, 1);
      repeat (60) @(posedge clkin);
      #1;
      check("abort_no_valid", valid_seen, 0);
      enable = 1'b1;
      wait_valid(cyc);
      check("reenable_latency", cyc, FIRST_LAT);
      check("reenable_count", count_o, 25);
      check("reenable_locked_w1", locked, 0);
      wait_valid(cyc);
      check("reenable_locked_w2", locked, 1);

      // Synchronous reset mid-window while locked.
      repeat (30) @(posedge clkin);
      #1;
      reset = 1'b1;
      @(posedge clkin);
      #1;
      check("mid_rst_count_o", count_o, 0);
      check("mid_rst_count_valid", count_valid, 0);
      check("mid_rst_in_range", in_range, 0);
      check("mid_rst_locked", locked, 0);
      check("mid_rst_fail", fail, 0);
      reset = 1'b0;
      wait_valid(cyc);
      check("post_rst_latency", cyc, FIRST_LAT);
      check("post_rst_count", count_o, 25);
      check("post_rst_locked_w1", locked, 0);
      wait_valid(cyc);
      check("post_rst_locked_w2", locked, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_freq_monitor.md
Name: clk_freq_monitor

Overview:
- Single-clock checker for the other end of the on-board PLL. It measures a PLL-derived test signal by counting its rising edges over a fixed gate window of the 100 MHz system clock.
- Each window's count is compared against an expected value within a tolerance. From that result the block derives a debounced "locked" indication.
- It feeds the LED driver enable and status LEDs, so downstream logic runs only while the generated clock is correct.

Parameters:
- GATE_CYCLES, 100000, gate window length in clkin cycles (1 ms at 100 MHz).
- CNT_W, 20, width of edge counter and count_o.
- EXPECTED, 25000, nominal edges per window.
- TOL, 250, allowed absolute deviation from EXPECTED (inclusive).
- LOCK_WINDOWS, 4, consecutive in-range windows required to assert locked.
- SETTLE, 4, clkin cycles spent in ARM before a window opens.

Ports:
- clkin  input  1  system clock, sole clock domain.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run measurement; low returns the FSM to IDLE.
- sig_in  input  1  asynchronous test signal, must be below clkin/2; synchronized internally.
- count_o  output  CNT_W  edge count of the last completed window.
- count_valid  output  1  one-cycle pulse when count_o updates.
- in_range  output  1  last window satisfied |count-EXPECTED| <= TOL.
- locked  output  1  debounced lock status.
- fail  output  1  one-cycle pulse on an out-of-range window.

Behaviour:
- Reset values: count_o=0, count_valid=0, in_range=0, locked=0, fail=0, FSM=IDLE, internal counters=0, synchronizer FFs=0.
- Synchronizer and edge detect:
  - Two FFs, then a delay FF.
  - edge = sync2 & ~sync3.
  - Latency is 3 clkin cycles from sig_in rising to the edge pulse.
- FSM states:
  - IDLE: counters cleared, outputs hold their last values except locked, which is forced to 0. Go to ARM when enable=1.
  - ARM: wait SETTLE cycles, then go to MEASURE with gate_cnt=0 and edge_cnt=0. enable=0 returns to IDLE.
  - MEASURE: lasts exactly GATE_CYCLES cycles. edge_cnt increments on each edge pulse and saturates at 2^CNT_W-1.
- End of window, on the cycle with gate_cnt==GATE_CYCLES-1:
  - The result includes that cycle's edge.
  - Next cycle: count_o=result, count_valid=1, in_range=compare(result).
  - fail=1 if out of range.
  - edge_cnt restarts at 0; an edge on that next cycle counts into the new window.
  - With enable still 1, the next window starts back-to-back with no dead cycle. If enable=0 at the boundary, go to IDLE and skip the result update.
- Compare: computed on a widened (CNT_W+1) signed difference, so there is no wrap. in_range = (result >= EXPECTED-TOL) && (result <= EXPECTED+TOL); a lower bound below 0 clamps to 0.
- Lock counter (saturating, 0..LOCK_WINDOWS):
  - In-range window: counter increments.
  - Out-of-range window: counter clears and locked drops on the same cycle as fail.
  - locked rises on the count_valid cycle where the counter reaches LOCK_WINDOWS.
- enable deassert mid-window: abort, discard the partial count, locked=0 next cycle. count_o and in_range keep their last values.
- reset mid-window: all state returns to reset values next cycle; reset has priority over enable.
- sig_in stuck high or low: count 0, treated as out of range.

Test Plan (sim params GATE_CYCLES=100, EXPECTED=25, TOL=1, LOCK_WINDOWS=2, SETTLE=4, CNT_W=8):
- sig_in period 4 clkin, enable=1 after reset:
  - count_valid pulses every 100 cycles.
  - count_o=25 and in_range=1.
  - locked=1 at the 2nd count_valid.
  - fail never pulses.
- sig_in period 5 while locked:
  - At the 1st window that is entirely at period 5: count_o=20, in_range=0, fail=1, locked=0 in the same cycle.
  - Restoring period 4 gives locked=1 after 2 in-range windows.
- Tolerance edges:
  - Windows with 24 and 26 edges: in_range=1.
  - Windows with 23 and 27 edges: in_range=0 and fail=1.
- sig_in held at 0: count_o=0, fail=1 each window, locked stays 0.
- enable dropped at gate cycle 50, then re-raised:
  - No count_valid for the aborted window; locked=0 next cycle.
  - The first count_valid comes SETTLE+100+1 cycles after re-enable (plus IDLE exit cycle).
- reset asserted mid-window while locked: next cycle all outputs are 0. The sequence resumes correctly after release.
